plugin_stress_seq: RTL and testbench
====================================

// Module: plugin_stress_seq
// PURPOSE
//   Parametrised saturation/overflow stress plugin: on start, emits a burst of NUM_VECTORS warp vectors
//   over a valid/ready handshake, not one static latched vector. Four selectable patterns (saturate,
//   alternating-sign, saturating ramp, wrapping ramp) exercise accumulator overflow, symmetry and
//   error-threshold paths. Sits in the plugin bank beside the fixed-pattern reference plugins.
// PARAMETERS
//   WARP_WIDTH   16      bits per warp component, two's complement
//   ERROR_WIDTH  32      bits of plugin_error
//   PLUGIN_ID    4       plugin identifier; offsets the Z pattern
//   NUM_VECTORS  4       vectors per burst, >=1; counter k width = max(1,$clog2(NUM_VECTORS))
//   RAMP_STEP    'h0800  per-vector step for ramp modes, signed
//   ERROR_BASE   5       error reported on vector 0
// PORTS
//   clk            in   1           clock
//   rst_n          in   1           asynchronous active-low reset
//   start          in   1           begin burst (honoured only in IDLE)
//   mode           in   2           pattern select, sampled with start: 0 SAT, 1 ALT, 2 RAMP, 3 WRAP
//   abort          in   1           terminate burst immediately
//   out_ready      in   1           consumer accepts current vector
//   plugin_valid   out  1           vector k presented
//   plugin_warp_x  out  WARP_WIDTH  X component
//   plugin_warp_y  out  WARP_WIDTH  Y component
//   plugin_warp_z  out  WARP_WIDTH  Z component
//   plugin_error   out  ERROR_WIDTH error metric for vector k
//   plugin_last    out  1           asserted with plugin_valid on vector NUM_VECTORS-1
//   plugin_busy    out  1           FSM in RUN
//   plugin_done    out  1           one-cycle pulse after final beat accepted
// BEHAVIOUR
//   Reset: async on rst_n low. All outputs 0, FSM IDLE, k=0, latched mode=0.
//   FSM IDLE->RUN: start & !abort. Latch mode, k=0. Vector 0 and plugin_valid registered for next edge
//     (1-cycle latency start->valid).
//   FSM RUN: beat = plugin_valid & out_ready. On beat with k<NUM_VECTORS-1: k++, next vector registered,
//     valid stays 1 (back-to-back, no bubble). On beat with k==NUM_VECTORS-1: ->DONE, valid/last drop next edge.
//   Backpressure: valid & !out_ready holds all outputs and k stable. Valid never drops without a beat
//     except on abort/reset.
//   FSM DONE: plugin_done=1 for exactly one cycle, then ->IDLE. Warp/error hold last values; valid 0.
//   abort (any state, priority over start and beat): ->IDLE next edge; valid, last, busy, done =0; no done pulse.
//   start while RUN/DONE: ignored. mode changes after start: ignored until next burst.
//   Arithmetic: MAX_POS={0,1..1}, MAX_NEG={1,0..0}. Terms computed signed in WARP_WIDTH+16 bits.
//     sat(v) clamps to [MAX_NEG,MAX_POS]. wrap(v)=v[WARP_WIDTH-1:0].
//     SAT : X=MAX_POS, Y=MAX_NEG, Z=sat(PLUGIN_ID*RAMP_STEP), constant for all k
//     ALT : k even (MAX_POS,MAX_NEG,MAX_POS); k odd (MAX_NEG,MAX_POS,MAX_NEG)
//     RAMP: X=sat(k*S), Y=sat(-k*S), Z=sat((PLUGIN_ID+k)*S), S=RAMP_STEP
//     WRAP: same expressions as RAMP, wrap() instead of sat()
//   Error: plugin_error = ERROR_BASE+k, saturating at all-ones in ERROR_WIDTH (no wrap).
//   NUM_VECTORS=1: single beat, plugin_last asserted with it.
// TESTING (defaults unless noted; ready=1 unless noted)
//   1 SAT: start, mode=0 -> valid 1 cycle later; 4 beats of (7FFF,8000,2000), err 5,6,7,8; last on beat 4;
//     done pulse next cycle; busy 0 after.
//   2 RAMP/WRAP, NUM_VECTORS=20, k=16: RAMP -> (7FFF,8000,7FFF); WRAP -> (8000,8000,A000); k=1 RAMP -> (0800,F800,2800).
//   3 ALT with out_ready low 3 cycles at k=1 -> (8000,7FFF,8000), err 6 held stable, k held;
//     resumes k=2 (7FFF,8000,7FFF).
//   4 abort at k=2 (also abort with start same cycle) -> valid/busy 0 next edge, no done; new start bursts from k=0.
//   5 start pulsed and mode changed mid-burst -> ignored; burst completes with original mode and 4 beats.
//   6 rst_n low mid-RUN, async -> all outputs 0 before next edge; after release idle until start.

Source files
------------

// File: rtl/plugin_stress_seq.sv
// plugin_stress_seq: saturation/overflow stress plugin.
// On start it emits a burst of NUM_VECTORS warp vectors over a valid/ready
// handshake. There are four patterns: saturate, alternating sign, saturating
// ramp and wrapping ramp.
module plugin_stress_seq #(
    parameter int          WARP_WIDTH  = 16,
    parameter int          ERROR_WIDTH = 32,
    parameter int          PLUGIN_ID   = 4,
    parameter int          NUM_VECTORS = 4,
    parameter int          RAMP_STEP   = 'h0800,
    parameter int unsigned ERROR_BASE  = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic                   abort,
    input  logic                   out_ready,
    output logic                   plugin_valid,
    output logic [WARP_WIDTH-1:0]  plugin_warp_x,
    output logic [WARP_WIDTH-1:0]  plugin_warp_y,
    output logic [WARP_WIDTH-1:0]  plugin_warp_z,
    output logic [ERROR_WIDTH-1:0] plugin_error,
    output logic                   plugin_last,
    output logic                   plugin_busy,
    output logic                   plugin_done
);

    localparam int KW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam int TW = WARP_WIDTH + 16;

    localparam logic [KW-1:0]          LAST_K  = KW'(NUM_VECTORS - 1);
    localparam logic [WARP_WIDTH-1:0]  MAX_POS = {1'b0, {(WARP_WIDTH-1){1'b1}}};
    localparam logic [WARP_WIDTH-1:0]  MAX_NEG = {1'b1, {(WARP_WIDTH-1){1'b0}}};
    localparam logic signed [TW-1:0]   POS_T   = {{17{1'b0}}, {(WARP_WIDTH-1){1'b1}}};
    localparam logic signed [TW-1:0]   NEG_T   = {{17{1'b1}}, {(WARP_WIDTH-1){1'b0}}};
    localparam logic signed [TW-1:0]   STEP    = TW'(RAMP_STEP);
    localparam logic signed [TW-1:0]   PID_T   = TW'(PLUGIN_ID);
    localparam logic [ERROR_WIDTH-1:0] EBASE   = ERROR_WIDTH'(ERROR_BASE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {M_SAT, M_ALT, M_RAMP, M_WRAP} mode_t;

    state_t                 state, state_n;
    mode_t                  mode_q, mode_n, gen_mode;
    logic [KW-1:0]          k, k_n, k_inc, gen_k;
    logic                   load;
    logic                   valid_n, last_n, done_n;
    logic [WARP_WIDTH-1:0]  x_n, y_n, z_n;
    logic [ERROR_WIDTH-1:0] err_n;

    function automatic logic [WARP_WIDTH-1:0] sat_w(input logic signed [TW-1:0] v);
        if (v > POS_T)
            return MAX_POS;
        else if (v < NEG_T)
            return MAX_NEG;
        else
            return v[WARP_WIDTH-1:0];
    endfunction

    function automatic logic [3*WARP_WIDTH-1:0] gen_vec(input mode_t m, input logic [KW-1:0] kk);
        logic signed [TW-1:0] kt, tx, ty, tz;
        kt = signed'(TW'(kk));
        tx = kt * STEP;
        ty = -tx;
        tz = (PID_T + kt) * STEP;
        case (m)
            M_SAT:   return {MAX_POS, MAX_NEG, sat_w(PID_T * STEP)};
            M_ALT:   return kk[0] ? {MAX_NEG, MAX_POS, MAX_NEG} : {MAX_POS, MAX_NEG, MAX_POS};
            M_RAMP:  return {sat_w(tx), sat_w(ty), sat_w(tz)};
            default: return {tx[WARP_WIDTH-1:0], ty[WARP_WIDTH-1:0], tz[WARP_WIDTH-1:0]};
        endcase
    endfunction

    function automatic logic [ERROR_WIDTH-1:0] gen_err(input logic [KW-1:0] kk);
        logic [ERROR_WIDTH:0] sum;
        sum = {1'b0, EBASE} + (ERROR_WIDTH+1)'(kk);
        return sum[ERROR_WIDTH] ? '1 : sum[ERROR_WIDTH-1:0];
    endfunction

    assign plugin_busy = (state == S_RUN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Next state, and the next vector when a new beat is loaded; abort overrides everything.
    always_comb begin
        state_n  = state;
        mode_n   = mode_q;
        k_n      = k;
        k_inc    = k + 1'b1;
        gen_mode = mode_q;
        gen_k    = k;
        load     = 1'b0;
        valid_n  = plugin_valid;
        last_n   = plugin_last;
        done_n   = 1'b0;
        x_n      = plugin_warp_x;
        y_n      = plugin_warp_y;
        z_n      = plugin_warp_z;
        err_n    = plugin_error;
        if (abort) begin
            state_n = S_IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_n  = S_RUN;
                        mode_n   = mode_t'(mode);
                        k_n      = '0;
                        gen_mode = mode_t'(mode);
                        gen_k    = '0;
                        load     = 1'b1;
                        valid_n  = 1'b1;
                        last_n   = (NUM_VECTORS == 1);
                    end
                end
                S_RUN: begin
                    if (plugin_valid && out_ready) begin
                        if (k == LAST_K) begin
                            state_n = S_DONE;
                            valid_n = 1'b0;
                            last_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            k_n     = k_inc;
                            gen_k   = k_inc;
                            load    = 1'b1;
                            valid_n = 1'b1;
                            last_n  = (k_inc == LAST_K);
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
        if (load) begin
            {x_n, y_n, z_n} = gen_vec(gen_mode, gen_k);
            err_n           = gen_err(gen_k);
        end
    end

    // Datapath and handshake output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= M_SAT;
            k             <= '0;
            plugin_valid  <= 1'b0;
            plugin_last   <= 1'b0;
            plugin_done   <= 1'b0;
            plugin_warp_x <= '0;
            plugin_warp_y <= '0;
            plugin_warp_z <= '0;
            plugin_error  <= '0;
        end else begin
            mode_q        <= mode_n;
            k             <= k_n;
            plugin_valid  <= valid_n;
            plugin_last   <= last_n;
            plugin_done   <= done_n;
            plugin_warp_x <= x_n;
            plugin_warp_y <= y_n;
            plugin_warp_z <= z_n;
            plugin_error  <= err_n;
        end
    end

endmodule

// File: tb/tb_plugin_stress_seq.sv
// Testbench for plugin_stress_seq: table vectors, hand-written corner sequences
// and randomized bursts, all checked against a behavioural model.
module tb_plugin_stress_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic        start = 0, abort = 0, out_ready = 1;
    logic [1:0]  mode = 0;
    logic        valid, last, busy, done;
    logic [15:0] wx, wy, wz;
    logic [31:0] err;

    // shared stimulus for the 20-vector and 1-vector instances
    logic        start_b = 0, abort_b = 0, ready_b = 1;
    logic [1:0]  mode_b = 0;
    logic        c_valid, c_last, c_busy, c_done;
    logic [15:0] c_x, c_y, c_z;
    logic [31:0] c_err;
    logic        d_valid, d_last, d_busy, d_done;
    logic [15:0] d_x, d_y, d_z;
    logic [31:0] d_err;

    plugin_stress_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort), .out_ready(out_ready),
        .plugin_valid(valid), .plugin_warp_x(wx), .plugin_warp_y(wy), .plugin_warp_z(wz),
        .plugin_error(err), .plugin_last(last), .plugin_busy(busy), .plugin_done(done));

    plugin_stress_seq #(.NUM_VECTORS(20), .ERROR_BASE(32'hFFFF_FFF0)) dut20 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b), .abort(abort_b), .out_ready(ready_b),
        .plugin_valid(c_valid), .plugin_warp_x(c_x), .plugin_warp_y(c_y), .plugin_warp_z(c_z),
        .plugin_error(c_err), .plugin_last(c_last), .plugin_busy(c_busy), .plugin_done(c_done));

    plugin_stress_seq #(.NUM_VECTORS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b), .abort(abort_b), .out_ready(ready_b),
        .plugin_valid(d_valid), .plugin_warp_x(d_x), .plugin_warp_y(d_y), .plugin_warp_z(d_z),
        .plugin_error(d_err), .plugin_last(d_last), .plugin_busy(d_busy), .plugin_done(d_done));

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [15:0] x, y, z;
        logic [31:0] err;
    } vec_t;

    typedef struct {
        int          m;
        int          k;
        logic [15:0] x, y, z;
        logic [31:0] err;
    } tv_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic longint clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: pattern rules written directly as integer arithmetic.
    function automatic vec_t model(input int m, input int k, input longint base);
        longint s = 2048;
        longint p = 4;
        longint vx, vy, vz, e;
        vec_t r;
        case (m)
            0: begin vx = 32767; vy = -32768; vz = clamp16(p * s); end
            1: begin
                if (k % 2 == 0) begin vx = 32767; vy = -32768; vz = 32767; end
                else begin vx = -32768; vy = 32767; vz = -32768; end
            end
            2: begin vx = clamp16(k * s); vy = clamp16(-k * s); vz = clamp16((p + k) * s); end
            default: begin vx = k * s; vy = -k * s; vz = (p + k) * s; end
        endcase
        e = base + k;
        if (e > 64'hFFFF_FFFF) e = 64'hFFFF_FFFF;
        r.x = vx[15:0];
        r.y = vy[15:0];
        r.z = vz[15:0];
        r.err = e[31:0];
        return r;
    endfunction

    task automatic chk_vec(input string nm, input logic [15:0] ax, input logic [15:0] ay,
                           input logic [15:0] az, input logic [31:0] ae, input vec_t e);
        chk({nm, "_x"}, 64'(ax), 64'(e.x));
        chk({nm, "_y"}, 64'(ay), 64'(e.y));
        chk({nm, "_z"}, 64'(az), 64'(e.z));
        chk({nm, "_err"}, 64'(ae), 64'(e.err));
    endtask

    // One 4-beat burst on the default instance, every cycle checked against the model.
    // stall_pct: random backpressure percentage; stall_k/stall_n: forced stall at one beat;
    // perturb: toggle start/mode randomly while the burst runs.
    task automatic run_burst(input int m, input int stall_pct, input int stall_k,
                             input int stall_n, input bit perturb, input string nm);
        int   kk = 0;
        int   stalls = 0;
        int   cyc = 0;
        logic r;
        @(negedge clk);
        start = 1; mode = 2'(m); out_ready = 1;
        @(negedge clk);
        start = 0;
        while (kk < 4 && cyc < 300) begin
            cyc++;
            chk({nm, "_valid"}, 64'(valid), 64'(1));
            chk({nm, "_busy"}, 64'(busy), 64'(1));
            chk({nm, "_last"}, 64'(last), 64'(kk == 3));
            chk({nm, "_done"}, 64'(done), 64'(0));
            chk_vec(nm, wx, wy, wz, err, model(m, kk, 5));
            if (kk == stall_k && stalls < stall_n) begin
                r = 0; stalls++;
            end else if (stall_pct > 0) begin
                r = ($urandom_range(0, 99) >= stall_pct);
            end else begin
                r = 1;
            end
            out_ready = r;
            if (perturb) begin
                start = 1'($urandom_range(0, 1));
                mode = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            if (r) kk++;
        end
        if (kk < 4) begin
            n_chk++;
            $display("FAIL %s_timeout: got %0d beats expected 4", nm, kk);
        end
        start = 0; out_ready = 1;
        chk({nm, "_end_valid"}, 64'(valid), 64'(0));
        chk({nm, "_end_last"}, 64'(last), 64'(0));
        chk({nm, "_end_busy"}, 64'(busy), 64'(0));
        chk({nm, "_end_done"}, 64'(done), 64'(1));
        chk_vec({nm, "_hold"}, wx, wy, wz, err, model(m, 3, 5));
        @(negedge clk);
        chk({nm, "_idle_done"}, 64'(done), 64'(0));
        chk({nm, "_idle_valid"}, 64'(valid), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tv_t tab[10];
        tab[0] = '{0, 0,  16'h7FFF, 16'h8000, 16'h2000, 32'hFFFF_FFF0};
        tab[1] = '{0, 19, 16'h7FFF, 16'h8000, 16'h2000, 32'hFFFF_FFFF};
        tab[2] = '{1, 1,  16'h8000, 16'h7FFF, 16'h8000, 32'hFFFF_FFF1};
        tab[3] = '{1, 2,  16'h7FFF, 16'h8000, 16'h7FFF, 32'hFFFF_FFF2};
        tab[4] = '{2, 1,  16'h0800, 16'hF800, 16'h2800, 32'hFFFF_FFF1};
        tab[5] = '{2, 15, 16'h7800, 16'h8800, 16'h7FFF, 32'hFFFF_FFFF};
        tab[6] = '{2, 16, 16'h7FFF, 16'h8000, 16'h7FFF, 32'hFFFF_FFFF};
        tab[7] = '{3, 16, 16'h8000, 16'h8000, 16'hA000, 32'hFFFF_FFFF};
        tab[8] = '{3, 19, 16'h9800, 16'h6800, 16'hB800, 32'hFFFF_FFFF};
        tab[9] = '{2, 0,  16'h0000, 16'h0000, 16'h2000, 32'hFFFF_FFF0};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_last", 64'(last), 64'(0));
        chk_vec("rst", wx, wy, wz, err, '{16'h0, 16'h0, 16'h0, 32'h0});
        rst_n = 1;
        @(negedge clk);
        chk("idle_valid", 64'(valid), 64'(0));

        // single-vector instance: last rides with the only beat
        start_b = 1; mode_b = 2;
        @(negedge clk);
        start_b = 0;
        chk("n1_valid", 64'(d_valid), 64'(1));
        chk("n1_last", 64'(d_last), 64'(1));
        chk("n1_busy", 64'(d_busy), 64'(1));
        chk_vec("n1", d_x, d_y, d_z, d_err, model(2, 0, 5));
        @(negedge clk);
        chk("n1_end_valid", 64'(d_valid), 64'(0));
        chk("n1_end_done", 64'(d_done), 64'(1));
        chk("n1_end_busy", 64'(d_busy), 64'(0));
        abort_b = 1;
        @(negedge clk);
        abort_b = 0;
        chk("n1_idle_done", 64'(d_done), 64'(0));

        // table vectors on the 20-vector instance
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start_b = 1; mode_b = 2'(tab[i].m);
            @(negedge clk);
            start_b = 0;
            for (int j = 0; j < tab[i].k; j++) @(negedge clk);
            chk("tab_valid", 64'(c_valid), 64'(1));
            chk("tab_last", 64'(c_last), 64'(tab[i].k == 19));
            chk_vec("tab", c_x, c_y, c_z, c_err, '{tab[i].x, tab[i].y, tab[i].z, tab[i].err});
            abort_b = 1;
            @(negedge clk);
            abort_b = 0;
            chk("tab_abort_valid", 64'(c_valid), 64'(0));
            chk("tab_abort_done", 64'(c_done), 64'(0));
        end

        // SAT burst, then ALT with a 3-cycle stall at k=1
        run_burst(0, 0, -1, 0, 0, "sat");
        run_burst(1, 0, 1, 3, 0, "alt_stall");

        // abort at k=2, then abort+start together in IDLE
        @(negedge clk);
        start = 1; mode = 3;
        @(negedge clk);
        start = 0; out_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk_vec("abort_k2", wx, wy, wz, err, model(3, 2, 5));
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_valid", 64'(valid), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_last", 64'(last), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        @(negedge clk);
        chk("abort_nodone", 64'(done), 64'(0));
        start = 1; abort = 1; mode = 0;
        @(negedge clk);
        start = 0; abort = 0;
        chk("abort_start_valid", 64'(valid), 64'(0));
        chk("abort_start_busy", 64'(busy), 64'(0));
        run_burst(1, 0, -1, 0, 0, "after_abort");

        // start/mode changes mid-burst are ignored
        run_burst(2, 0, -1, 0, 1, "perturb_ramp");
        run_burst(3, 30, -1, 0, 1, "perturb_wrap");

        // asynchronous reset mid-burst
        @(negedge clk);
        start = 1; mode = 2;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_valid", 64'(valid), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_last", 64'(last), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        chk_vec("arst", wx, wy, wz, err, '{16'h0, 16'h0, 16'h0, 32'h0});
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("arst_idle_valid", 64'(valid), 64'(0));
        @(negedge clk);
        chk("arst_idle_busy", 64'(busy), 64'(0));
        run_burst(2, 0, -1, 0, 0, "after_reset");

        // randomized bursts with backpressure and perturbation
        for (int i = 0; i < 20; i++)
            run_burst(int'($urandom_range(0, 3)), 40, -1, 0, 1'($urandom_range(0, 1)), "rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
